// File: rtl/pipe_ctrl.sv
// pipe_ctrl: load-use stalls, fetch redirects and drain-then-trap sequencing for an in-order pipeline
module pipe_ctrl #(
    parameter int XLEN      = 32,
    parameter int LD_STAGES = 2,
    parameter bit FWD_EN    = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   rs1_re,
    input  logic                   rs2_re,
    input  logic [4:0]             rs1_addr,
    input  logic [4:0]             rs2_addr,
    input  logic [LD_STAGES-1:0]   ld_valid,
    input  logic [5*LD_STAGES-1:0] ld_rd,
    input  logic                   jump,
    input  logic                   branch_taken,
    input  logic [XLEN-1:0]        jump_target,
    input  logic [XLEN-1:0]        branch_target,
    input  logic                   exc_valid,
    input  logic [3:0]             exc_cause,
    input  logic [XLEN-1:0]        exc_pc,
    input  logic                   irq_pending,
    input  logic [XLEN-1:0]        irq_pc,
    input  logic                   mret,
    input  logic [XLEN-1:0]        mepc,
    input  logic [XLEN-1:0]        mtvec,
    input  logic                   ex_ready,
    input  logic                   mem_ready,
    input  logic                   wb_ready,
    output logic                   set_pc_valid,
    output logic [XLEN-1:0]        set_pc,
    output logic                   stall_if,
    output logic                   stall_id,
    output logic                   stall_ex,
    output logic                   stall_mem,
    output logic                   flush_if,
    output logic                   flush_id,
    output logic                   flush_ex,
    output logic                   trap_take,
    output logic [4:0]             trap_cause,
    output logic [XLEN-1:0]        trap_epc,
    output logic [31:0]            stall_cnt
);
    localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, TRAP = 2'd2;
    logic [1:0] state, state_nxt;
    logic load_stall, run, drain, trap, accept, norm, redirect, hold, pipe_stall;
    always_comb begin
        load_stall = 1'b0;
        for (int i = 0; i < LD_STAGES; i++)
            if (!FWD_EN || i == 0)
                load_stall = load_stall | (ld_valid[i] &
                    ((rs1_re & (rs1_addr != 5'd0) & (rs1_addr == ld_rd[5*i +: 5])) |
                     (rs2_re & (rs2_addr != 5'd0) & (rs2_addr == ld_rd[5*i +: 5]))));
    end
    // While reset is held the block behaves as RUN with traps suppressed
    assign run        = !reset_n || state == RUN;
    assign drain      = reset_n && state == DRAIN;
    assign trap       = reset_n && state == TRAP;
    assign accept     = run && reset_n && (exc_valid || irq_pending);
    assign norm       = run && !accept;
    assign redirect   = norm && (jump || branch_taken || mret);
    assign hold       = accept || drain;
    assign pipe_stall = !wb_ready || !mem_ready || !ex_ready || load_stall;
    assign set_pc_valid = redirect || trap;
    assign set_pc     = trap ? mtvec : !redirect ? '0 : mret ? mepc : jump ? jump_target : branch_target;
    assign flush_if   = hold || set_pc_valid;
    assign flush_id   = hold || set_pc_valid || (norm && load_stall && mem_ready);
    assign flush_ex   = hold;
    assign stall_if   = hold || (norm && pipe_stall);
    assign stall_id   = norm && pipe_stall;
    assign stall_ex   = norm && (!wb_ready || !mem_ready);
    assign stall_mem  = norm && !wb_ready;
    assign trap_take  = trap;
    assign state_nxt  = accept ? DRAIN : drain ? ((mem_ready && wb_ready) ? TRAP : DRAIN) : RUN;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= RUN;
            trap_epc   <= '0;
            trap_cause <= '0;
            stall_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= stall_cnt + 32'(stall_if);
            if (accept) begin
                trap_epc   <= exc_valid ? exc_pc : irq_pc;
                trap_cause <= exc_valid ? {1'b0, exc_cause} : {1'b1, 4'd11};
            end
        end
    end
endmodule
